// File: rtl/mul_div_pkg.sv
// Shared types and constants for the multi-cycle unsigned multiply/divide unit.
package mul_div_pkg;

    localparam int BIT_SIZE = 32;

    localparam logic OP_MULTU = 1'b0;
    localparam logic OP_DIVU  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Wide enough to hold every value from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

    localparam int CNT_W = cnt_width(BIT_SIZE);

endpackage

// File: rtl/mul_div_step.sv
// One combinational iteration of shift-add multiply or restoring divide over an {acc, low} register pair.
module mul_div_step
    import mul_div_pkg::*;
#(
    parameter int bit_size = BIT_SIZE
) (
    input  logic                op_i,
    input  logic [bit_size-1:0] acc_i,
    input  logic [bit_size-1:0] low_i,
    input  logic [bit_size-1:0] operand_i,
    output logic [bit_size-1:0] acc_o,
    output logic [bit_size-1:0] low_o
);

    logic [bit_size:0] sum;
    logic [bit_size:0] shifted;
    logic [bit_size:0] diff;
    logic              fits;

    always_comb begin
        sum     = {1'b0, acc_i} + {1'b0, operand_i};
        shifted = {acc_i, low_i[bit_size-1]};
        diff    = shifted - {1'b0, operand_i};
        fits    = (shifted >= {1'b0, operand_i});
        acc_o   = acc_i;
        low_o   = low_i;
        if (op_i == OP_MULTU) begin
            // Product bits retire into low as the multiplier shifts out of its bottom.
            if (low_i[0]) begin
                {acc_o, low_o} = {sum, low_i[bit_size-1:1]};
            end else begin
                {acc_o, low_o} = {1'b0, acc_i, low_i[bit_size-1:1]};
            end
        end else begin
            acc_o = fits ? diff[bit_size-1:0] : shifted[bit_size-1:0];
            low_o = {low_i[bit_size-2:0], fits};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULTU/DIVU unit owning HI/LO; one iteration per cycle, results land on the final iteration edge.
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int bit_size = BIT_SIZE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic                op_i,
    input  logic [bit_size-1:0] src_a_i,
    input  logic [bit_size-1:0] src_b_i,
    input  logic                hi_we_i,
    input  logic                lo_we_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                div_by_zero_o,
    output logic [bit_size-1:0] hi_o,
    output logic [bit_size-1:0] lo_o
);

    localparam int CntW = cnt_width(bit_size);

    state_e              state_q, state_d;
    logic [CntW-1:0]     cnt_q;
    logic                op_q;
    logic [bit_size-1:0] acc_q, low_q, operand_q;
    logic [bit_size-1:0] hi_q, lo_q;
    logic                dbz_q;
    logic [bit_size-1:0] accNext, lowNext;
    logic                startAccepted, lastIter;

    assign startAccepted = start_i && (state_q != S_RUN);
    assign lastIter      = (state_q == S_RUN) && (cnt_q == CntW'(bit_size - 1));

    mul_div_step #(.bit_size(bit_size)) u_step (
        .op_i      (op_q),
        .acc_i     (acc_q),
        .low_i     (low_q),
        .operand_i (operand_q),
        .acc_o     (accNext),
        .low_o     (lowNext)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_RUN;
            S_RUN:   if (lastIter) state_d = S_DONE;
            S_DONE:  state_d = start_i ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o        = (state_q == S_RUN);
        done_o        = (state_q == S_DONE);
        div_by_zero_o = dbz_q;
        hi_o          = hi_q;
        lo_o          = lo_q;
    end

    // Multiplier sits in low and multiplicand is the added operand; for divide the dividend shifts out of low instead.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            op_q      <= OP_MULTU;
            acc_q     <= '0;
            low_q     <= '0;
            operand_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            if (startAccepted) begin
                op_q  <= op_i;
                cnt_q <= '0;
                acc_q <= '0;
                if (op_i == OP_DIVU) begin
                    low_q     <= src_a_i;
                    operand_q <= src_b_i;
                end else begin
                    low_q     <= src_b_i;
                    operand_q <= src_a_i;
                end
            end else if (state_q == S_RUN) begin
                acc_q <= accNext;
                low_q <= lowNext;
                cnt_q <= cnt_q + CntW'(1);
                if (lastIter) begin
                    hi_q  <= accNext;
                    lo_q  <= lowNext;
                    dbz_q <= (op_q == OP_DIVU) && (operand_q == '0);
                end
            end
            if (state_q != S_RUN) begin
                if (hi_we_i) hi_q <= src_a_i;
                if (lo_we_i) lo_q <= src_a_i;
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: a vector table of complete operations plus hand-written multi-cycle corner sequences.
module tb_mul_div_unit;

    localparam int N = 32;

    logic          clk = 1'b0;
    logic          rst, start, op, hiWe, loWe;
    logic [N-1:0]  srcA, srcB;
    logic          busy, done, divByZero;
    logic [N-1:0]  hi, lo;

    int testsRun = 0;
    int failures = 0;

    typedef struct {
        string        name;
        logic         op;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] expHi;
        logic [N-1:0] expLo;
        logic         expDbz;
    } vec_t;

    vec_t vecs[10];

    always #5 clk = ~clk;

    mul_div_unit #(.bit_size(N)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .op_i          (op),
        .src_a_i       (srcA),
        .src_b_i       (srcB),
        .hi_we_i       (hiWe),
        .lo_we_i       (loWe),
        .busy_o        (busy),
        .done_o        (done),
        .div_by_zero_o (divByZero),
        .hi_o          (hi),
        .lo_o          (lo)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Issues one start pulse and watches until done, counting busy cycles and catching any HI/LO movement mid-run.
    task automatic runOp(input logic opIn, input logic [N-1:0] a, input logic [N-1:0] b,
                         output int busyCycles, output logic gotDone, output logic holdBad);
        logic [N-1:0] oldHi, oldLo;
        @(negedge clk);
        op = opIn; srcA = a; srcB = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        oldHi = hi; oldLo = lo;
        busyCycles = 0; gotDone = 1'b0; holdBad = 1'b0;
        for (int i = 0; i < 100 && !gotDone; i++) begin
            @(negedge clk);
            if (done) gotDone = 1'b1;
            else if (busy) begin
                busyCycles++;
                if (hi !== oldHi || lo !== oldLo) holdBad = 1'b1;
            end
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int   busyCycles;
        logic gotDone, holdBad;
        runOp(v.op, v.a, v.b, busyCycles, gotDone, holdBad);
        checkOutput({v.name, "/done_seen"}, 64'(gotDone), 64'd1);
        checkOutput({v.name, "/busy_cycles"}, 64'(busyCycles), 64'd32);
        checkOutput({v.name, "/hold"}, 64'(holdBad), 64'd0);
        checkOutput({v.name, "/hi"}, 64'(hi), 64'(v.expHi));
        checkOutput({v.name, "/lo"}, 64'(lo), 64'(v.expLo));
        checkOutput({v.name, "/dbz"}, 64'(divByZero), 64'(v.expDbz));
        @(negedge clk);
        checkOutput({v.name, "/done_width"}, 64'(done), 64'd0);
        checkOutput({v.name, "/dbz_width"}, 64'(divByZero), 64'd0);
    endtask

    initial begin
        int           busyCycles, gap, doneCount;
        logic         gotDone, holdBad;
        logic [N-1:0] heldHi;

        vecs[0] = '{"mul_max",   1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1] = '{"div_100_7", 1'b1, 32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
        vecs[2] = '{"div_zero",  1'b1, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1};
        vecs[3] = '{"mul_16x16", 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
        vecs[4] = '{"div_by_1",  1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0};
        vecs[5] = '{"div_small", 1'b1, 32'd5,         32'd9,         32'd5,         32'd0,         1'b0};
        vecs[6] = '{"mul_zero",  1'b0, 32'h1234_5678, 32'd0,         32'd0,         32'd0,         1'b0};
        vecs[7] = '{"div_msb_3", 1'b1, 32'h8000_0000, 32'd3,         32'd2,         32'h2AAA_AAAA, 1'b0};
        vecs[8] = '{"mul_msb_2", 1'b0, 32'h8000_0000, 32'd2,         32'd1,         32'd0,         1'b0};
        vecs[9] = '{"mul_mixed", 1'b0, 32'h0000_FFFF, 32'h0001_0001, 32'd0,         32'hFFFF_FFFF, 1'b0};

        rst = 1'b1; start = 1'b0; op = 1'b0; hiWe = 1'b0; loWe = 1'b0; srcA = '0; srcB = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset/busy", 64'(busy), 64'd0);
        checkOutput("reset/done", 64'(done), 64'd0);
        checkOutput("reset/dbz", 64'(divByZero), 64'd0);
        checkOutput("reset/hi", 64'(hi), 64'd0);
        checkOutput("reset/lo", 64'(lo), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) applyStimulus(vecs[i]);

        // Restart attempt and MTHI mid-run must both be ignored.
        @(negedge clk);
        op = 1'b1; srcA = 32'd50; srcB = 32'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        heldHi = hi;
        busyCycles = 1;
        repeat (4) @(negedge clk);
        srcA = 32'd3; srcB = 32'd3; start = 1'b1; hiWe = 1'b1;
        @(negedge clk);
        start = 1'b0; hiWe = 1'b0;
        checkOutput("ignore/hi_held", 64'(hi), 64'(heldHi));
        checkOutput("ignore/still_busy", 64'(busy), 64'd1);
        gotDone = 1'b0;
        busyCycles = 5;
        for (int i = 0; i < 100 && !gotDone; i++) begin
            @(negedge clk);
            if (done) gotDone = 1'b1;
            else if (busy) busyCycles++;
        end
        checkOutput("ignore/done_seen", 64'(gotDone), 64'd1);
        checkOutput("ignore/busy_cycles", 64'(busyCycles), 64'd32);
        checkOutput("ignore/lo", 64'(lo), 64'd10);
        checkOutput("ignore/hi", 64'(hi), 64'd0);

        // Moves in IDLE, both together, then a move combined with an accepted start.
        @(negedge clk);
        srcA = 32'hAAAA_0000; hiWe = 1'b1;
        @(negedge clk);
        hiWe = 1'b0;
        checkOutput("mthi/hi", 64'(hi), 64'hAAAA_0000);
        srcA = 32'h0000_5555; loWe = 1'b1;
        @(negedge clk);
        loWe = 1'b0;
        checkOutput("mtlo/lo", 64'(lo), 64'h0000_5555);
        checkOutput("mtlo/hi_kept", 64'(hi), 64'hAAAA_0000);
        srcA = 32'h0000_CAFE; hiWe = 1'b1; loWe = 1'b1;
        @(negedge clk);
        hiWe = 1'b0; loWe = 1'b0;
        checkOutput("mtboth/hi", 64'(hi), 64'h0000_CAFE);
        checkOutput("mtboth/lo", 64'(lo), 64'h0000_CAFE);
        runOp(1'b0, 32'd3, 32'd4, busyCycles, gotDone, holdBad);
        checkOutput("mul_3_4/done_seen", 64'(gotDone), 64'd1);
        checkOutput("mul_3_4/hi", 64'(hi), 64'd0);
        checkOutput("mul_3_4/lo", 64'(lo), 64'd12);
        @(negedge clk);
        op = 1'b0; srcA = 32'd5; srcB = 32'd6; start = 1'b1; hiWe = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; hiWe = 1'b0;
        @(negedge clk);
        checkOutput("mthi_start/hi_moved", 64'(hi), 64'd5);
        checkOutput("mthi_start/busy", 64'(busy), 64'd1);
        gotDone = 1'b0;
        for (int i = 0; i < 100 && !gotDone; i++) begin
            @(negedge clk);
            if (done) gotDone = 1'b1;
        end
        checkOutput("mthi_start/done_seen", 64'(gotDone), 64'd1);
        checkOutput("mthi_start/hi", 64'(hi), 64'd0);
        checkOutput("mthi_start/lo", 64'(lo), 64'd30);

        // Reset in the middle of a run aborts it.
        @(negedge clk);
        op = 1'b0; srcA = 32'd7; srcB = 32'd6; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort/busy", 64'(busy), 64'd0);
        checkOutput("abort/done", 64'(done), 64'd0);
        checkOutput("abort/hi", 64'(hi), 64'd0);
        checkOutput("abort/lo", 64'(lo), 64'd0);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) doneCount++;
        end
        checkOutput("abort/no_activity", 64'(doneCount), 64'd0);

        // Back-to-back with start held through DONE.
        @(negedge clk);
        op = 1'b0; srcA = 32'd2; srcB = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 op = 1'b1; srcA = 32'd9; srcB = 32'd2;
        gotDone = 1'b0;
        for (int i = 0; i < 100 && !gotDone; i++) begin
            @(negedge clk);
            if (done) gotDone = 1'b1;
        end
        checkOutput("b2b/first_done", 64'(gotDone), 64'd1);
        checkOutput("b2b/first_hi", 64'(hi), 64'd0);
        checkOutput("b2b/first_lo", 64'(lo), 64'd6);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        checkOutput("b2b/no_idle", 64'(busy), 64'd1);
        gap = 1;
        gotDone = 1'b0;
        for (int i = 0; i < 100 && !gotDone; i++) begin
            @(negedge clk);
            gap++;
            if (done) gotDone = 1'b1;
        end
        checkOutput("b2b/second_done", 64'(gotDone), 64'd1);
        checkOutput("b2b/gap", 64'(gap), 64'd33);
        checkOutput("b2b/second_hi", 64'(hi), 64'd1);
        checkOutput("b2b/second_lo", 64'(lo), 64'd4);

        $display("[TB] %0d tests run, %0d failed", testsRun, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Multi-cycle unsigned multiply/divide unit owning the architectural HI/LO registers. Sits directly upstream of the write-back Mux4to1: its `hi`/`lo` outputs feed that mux's HI/LO inputs, which the control unit selects for MFHI/MFLO. The unit accepts one operation per start pulse, iterates one bit per cycle, and holds its results in HI/LO until overwritten.

## Interface
- `bit_size`, 32, operand width; HI and LO are each `bit_size` bits.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous, active-high reset.
- `start`  input  1  request a new operation; sampled on the rising edge.
- `op`  input  1  0 = MULTU, 1 = DIVU.
- `src_a`  input  bit_size  multiplicand or dividend; also the MTHI/MTLO data.
- `src_b`  input  bit_size  multiplier or divisor.
- `hi_we`  input  1  MTHI: write `src_a` into HI.
- `lo_we`  input  1  MTLO: write `src_a` into LO.
- `busy`  output  1  operation in progress; the CPU stalls on it.
- `done`  output  1  one-cycle pulse; HI/LO are valid for the completed operation.
- `div_by_zero`  output  1  the completed DIVU had `src_b == 0`; valid while `done` is high.
- `hi`  output  bit_size  HI register.
- `lo`  output  bit_size  LO register.

## Operation
- States:
  - IDLE: `busy=0`, `done=0`.
  - RUN: `busy=1`.
  - DONE: `done=1`, `busy=0`.
- Transitions:
  - IDLE→RUN on `start`.
  - RUN→DONE after exactly `bit_size` iteration edges.
  - DONE→RUN on `start`.
  - DONE→IDLE otherwise.
- On the edge where `start` is accepted, the unit latches `op`, `src_a` and `src_b` and clears the iteration counter.
- `start` while in RUN is ignored: no restart and no operand capture.
- MULTU: shift-add over a `2*bit_size` product register. Result `{hi,lo}` = `src_a*src_b`, full `2*bit_size`-bit width, no truncation.
- DIVU: restoring division. `lo` = quotient, `hi` = remainder.
- Divide by zero:
  - Still runs the full `bit_size` cycles.
  - Result: `lo` = all ones, `hi` = dividend.
  - `div_by_zero=1` during DONE.
- HI/LO are written only on the RUN→DONE edge. Intermediate values stay in internal registers, so `hi`/`lo` hold their old values throughout RUN.
- `hi_we`/`lo_we`:
  - Honoured in IDLE and DONE, on the edge they are high.
  - Ignored in RUN.
  - Both high together: HI and LO both take `src_a`.
  - Together with an accepted `start`: the move is performed and the new operation starts. Its result later overwrites HI/LO.
- Reset (synchronous, highest priority): state=IDLE, `hi=0`, `lo=0`, `busy=0`, `done=0`, `div_by_zero=0`, counter=0. A reset during RUN aborts the operation with no HI/LO update.

## Timing
- Latency: with `start` accepted on edge k, iterations occur on edges k+1 … k+`bit_size`. Edge k+`bit_size` writes HI/LO and enters DONE. `done` is high during the cycle following edge k+`bit_size` (k+32 for 32 bits).
- `busy` rises in the cycle after edge k and falls in the same cycle `done` rises.
- `done` and `div_by_zero` are exactly one cycle wide unless another operation completes back-to-back.
- Back-to-back throughput: a `start` held high in DONE begins the next operation with no IDLE cycle, giving `bit_size+1` cycles per operation.
- All outputs come directly from registers; there is no combinational path from inputs to outputs.

## Structure
- Shared package `mul_div_pkg`:
  - `OP_MULTU=1'b0`, `OP_DIVU=1'b1`.
  - State encoding `S_IDLE`, `S_RUN`, `S_DONE`.
  - Counter width `$clog2(bit_size+1)`.
- One sub-module `mul_div_step`: combinational single-iteration datapath.
  - Inputs: `op`, accumulator, operand.
  - Outputs: next accumulator and next quotient/product bits.
  - The top level keeps the FSM, counter and HI/LO registers.

## Test plan
- MULTU `0xFFFFFFFF × 0xFFFFFFFF`, `start` at edge 0 → `done` in the cycle after edge 32; `hi=0xFFFFFFFE`, `lo=0x00000001`; `busy` high for exactly 32 cycles.
- DIVU `100 / 7` → `lo=14`, `hi=2`, `div_by_zero=0`. Then DIVU `0x1234 / 0` → `lo=0xFFFFFFFF`, `hi=0x1234`, `div_by_zero=1` for one cycle.
- DIVU `50 / 5` in progress:
  - At RUN cycle 5, pulse `start` with `src_a=3`, `src_b=3` → ignored; result is `lo=10`, `hi=0`.
  - During RUN, `hi_we=1` → HI unchanged until `done`.
- MTHI `0xAAAA0000` and MTLO `0x5555` in IDLE → `hi`/`lo` update the next cycle. Then MULTU `3 × 4` → `hi=0`, `lo=12`.
- MULTU `7 × 6` with `rst` asserted at RUN cycle 10 → next cycle `busy=0`, `done=0`, `hi=0`, `lo=0`; `done` never asserts for the aborted operation.
- Back-to-back: hold `start` high through DONE with MULTU `2 × 3` then DIVU `9 / 2` → `done` pulses 33 cycles apart; results (6, 0) then (`lo=4`, `hi=1`).
